// File: rtl/bcd_convert_arbiter.sv
// Shared binary-to-BCD converter: two requesters arbitrated round-robin,
// serial double-dabble conversion (one bit per clock), registered tagged result.
module bcd_convert_arbiter #(
    parameter int N_BITS = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [N_BITS-1:0]     val0,
    input  logic                  req1,
    input  logic [N_BITS-1:0]     val1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  busy,
    output logic                  done,
    output logic                  id,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SH_W  = BCD_W + N_BITS;
    localparam int CNT_W = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state, state_nx;
    logic               rr_pref;
    logic [CNT_W-1:0]   cnt;
    logic               id_lat;
    logic [SH_W-1:0]    shreg;
    logic [SH_W-1:0]    sh_add;
    logic               grant_any;
    logic               grant_id;

    // Add 3 to every nibble that is 5 or more; nibbles never carry into each other.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign sh_add = {add3(shreg[SH_W-1 -: BCD_W]), shreg[N_BITS-1:0]};

    always_comb begin
        state_nx  = state;
        grant_any = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_any = 1'b1;
                    // rr_pref names the requester that wins a tie.
                    grant_id  = (req0 && req1) ? rr_pref : req1;
                    state_nx  = CONV;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(N_BITS - 1))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_pref <= 1'b0;
            cnt     <= '0;
            id_lat  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            id      <= 1'b0;
            bcd     <= '0;
        end else begin
            state <= state_nx;
            ack0  <= grant_any && !grant_id;
            ack1  <= grant_any && grant_id;
            done  <= (state == DONE);
            if (grant_any) begin
                rr_pref <= ~grant_id;
                id_lat  <= grant_id;
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (state == IDLE) begin
                busy <= 1'b0;
            end
            if (state == CONV)
                cnt <= cnt + CNT_W'(1);
            if (state == DONE) begin
                bcd <= shreg[SH_W-1 -: BCD_W];
                id  <= id_lat;
            end
        end
    end

    // Conversion datapath: loaded on grant, add-3 then shift on each CONV edge.
    always_ff @(posedge clk) begin
        if (grant_any)
            shreg <= {{BCD_W{1'b0}}, (grant_id ? val1 : val0)};
        else if (state == CONV)
            shreg <= {sh_add[SH_W-2:0], 1'b0};
    end

endmodule
